l15_req_port_arbiter: RTL

- Fixed-priority arbiter with anti-starvation that merges the per-source request ports (I$ miss, D$ miss, write-buffer, uncached read/write, AMO) into the single L1.5 request channel.
- Port 0 has the highest priority.
- Holds one registered request toward the L1.5 until it is acknowledged, and tags it with the originating port id so the return path can be demultiplexed.
- Sits between the per-port request formatters of the HPDC/L1.5 adapter and the l15_req output of the tile wrapper.

---
 rtl/l15_req_port_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/l15_req_port_arbiter.sv
// l15_req_port_arbiter
//   Merges NumPorts request sources into the single L1.5 request channel.
//   Port 0 has the highest priority. A port that has waited StarveTh cycles
//   is promoted ahead of the non-starved ports. One accepted request is held
//   in an output register, tagged with its port id, until l15_ack_i.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   req_valid_i    per-port request valid
//   req_payload_i  per-port payload, port i at [i*PayloadWidth +: PayloadWidth]
//   req_ready_o    per-port accept (one-hot or zero)
//   l15_val_o      request valid toward L1.5
//   l15_payload_o  held request payload
//   l15_portid_o   originating port of the held request
//   l15_ack_i      L1.5 accepts the held request
//   starved_o      per-port wait counter saturated
//   grant_cnt_o    total accepted requests (wraps)
module l15_req_port_arbiter #(
  parameter int unsigned NumPorts     = 6,
  parameter int unsigned PayloadWidth = 128,
  parameter int unsigned PortIdWidth  = $clog2(NumPorts),
  parameter int unsigned StarveTh     = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumPorts-1:0]              req_valid_i,
  input  logic [NumPorts*PayloadWidth-1:0] req_payload_i,
  output logic [NumPorts-1:0]              req_ready_o,
  output logic                             l15_val_o,
  output logic [PayloadWidth-1:0]          l15_payload_o,
  output logic [PortIdWidth-1:0]           l15_portid_o,
  input  logic                             l15_ack_i,
  output logic [NumPorts-1:0]              starved_o,
  output logic [31:0]                      grant_cnt_o
);

  localparam int unsigned CntWidth = $clog2(StarveTh + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(StarveTh);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e                  state;
  logic [CntWidth-1:0]     wait_cnt [NumPorts];
  logic [NumPorts-1:0]     starved_valid;
  logic [NumPorts-1:0]     accept_vec;
  logic [PortIdWidth-1:0]  sel;
  logic [PayloadWidth-1:0] sel_payload;
  logic                    free;
  logic                    any_valid;
  logic                    accept;
  logic                    found;

  always_comb begin
    starved_valid = '0;
    starved_o     = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      starved_o[i]     = (wait_cnt[i] == CntMax);
      starved_valid[i] = req_valid_i[i] && (wait_cnt[i] == CntMax);
    end
  end

  // Lowest-index starved requester wins; otherwise lowest-index requester.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (starved_valid[i] && !found) begin
        sel   = PortIdWidth'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (req_valid_i[i] && !found) begin
        sel   = PortIdWidth'(i);
        found = 1'b1;
      end
    end
  end

  assign any_valid = |req_valid_i;
  assign free      = (state == IDLE) || l15_ack_i;
  assign accept    = any_valid && free && !rst_i;

  always_comb begin
    accept_vec  = '0;
    sel_payload = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (sel == PortIdWidth'(i)) begin
        accept_vec[i] = accept;
        sel_payload   = req_payload_i[i*PayloadWidth +: PayloadWidth];
      end
    end
  end

  assign req_ready_o = accept_vec;

  // Output holding FSM; l15_val_o is the registered image of the HOLD state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      l15_val_o     <= 1'b0;
      l15_payload_o <= '0;
      l15_portid_o  <= '0;
      grant_cnt_o   <= '0;
    end else begin
      if (accept) begin
        grant_cnt_o <= grant_cnt_o + 32'd1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= HOLD;
            l15_val_o     <= 1'b1;
            l15_payload_o <= sel_payload;
            l15_portid_o  <= sel;
          end
        end
        HOLD: begin
          if (accept) begin
            l15_payload_o <= sel_payload;
            l15_portid_o  <= sel;
          end else if (l15_ack_i) begin
            state     <= IDLE;
            l15_val_o <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          l15_val_o <= 1'b0;
        end
      endcase
    end
  end

  // Wait counters keep running while the output is held, so starvation
  // builds up even when no slot is free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (!req_valid_i[i] || accept_vec[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CntMax) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule
